prng_step_scheduler: RTL and testbench

- Sequencer and arbiter for the PRNG datapath: the 16-bit data LFSR, the 8-bit control LFSR, the 16-to-8 bit-select mux and the two 7-segment decoders.
- Replaces divided/derived LFSR clocks with single-cycle step enables on `clk`.
- Shares fresh random bytes between the internal display refresh and two external requesters.
- Captures the mux output only after a full step-and-settle sequence, so no consumer ever sees a half-updated byte.

---
 rtl/prng_pkg.sv | 21 ++
 rtl/prng_tick_div.sv | 35 +++
 rtl/prng_step_scheduler.sv | 135 +++++++++++++
 tb/tb_prng_step_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and defaults for the PRNG step scheduler.
// State and owner encodings are used by the top and the bench.
package prng_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP    = 2'd1,
    S_SETTLE  = 2'd2,
    S_DELIVER = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_DISP = 2'd0,
    OWN_EXT0 = 2'd1,
    OWN_EXT1 = 2'd2
  } owner_e;

  localparam int TICK_DIV_DEF   = 10_000_000;
  localparam int CTRL_STEPS_DEF = 1;

endpackage

// File: rtl/prng_tick_div.sv
// Display refresh divider: counts 0..TICK_DIV-1 and flags each wrap.
// wrap_o is the same-edge wrap strobe; tick_o is its registered pulse.
module prng_tick_div
  import prng_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic wrap_o,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  assign wrap_o = en & (cnt_q == LAST);
  assign cnt_d  = wrap_o ? '0 : cnt_q + CW'(1);
  assign tick_o = tick_q;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap_o;
    end
  end

endmodule

// File: rtl/prng_step_scheduler.sv
// Sequences LFSR step enables and shares settled mux bytes between
// the display refresh and two round-robin external requesters.
module prng_step_scheduler
  import prng_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int CTRL_STEPS = CTRL_STEPS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [7:0] mux_byte,
  output logic       data_step,
  output logic       ctrl_step,
  output logic [1:0] gnt,
  output logic [7:0] rnd_byte,
  output logic [7:0] disp_byte,
  output logic       disp_tick,
  output logic       busy,
  output logic       disp_overrun
);

  localparam logic [3:0] LAST_STEP = 4'(CTRL_STEPS - 1);

  state_e     state_q;
  owner_e     owner_q, owner_d;
  logic [3:0] step_q;
  logic       last_q;
  logic       pend_q, pend_d;
  logic       ovr_q, ovr_set;
  logic       dstep_q, cstep_q, busy_q;
  logic [1:0] gnt_q;
  logic [7:0] rnd_q, disp_q;
  logic       wrap, clr;

  prng_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .wrap_o (wrap),
    .tick_o (disp_tick)
  );

  // Pending display request is consumed on the edge entering DELIVER
  assign clr     = (state_q == S_SETTLE) && (owner_q == OWN_DISP);
  assign pend_d  = wrap | (pend_q & ~clr);
  assign ovr_set = wrap & pend_q & ~clr;

  always_comb begin
    owner_d = OWN_DISP;
    unique case (1'b1)
      pend_q:                   owner_d = OWN_DISP;
      (!pend_q && req == 2'b11): owner_d = last_q ? OWN_EXT0 : OWN_EXT1;
      (!pend_q && req == 2'b01): owner_d = OWN_EXT0;
      (!pend_q && req == 2'b10): owner_d = OWN_EXT1;
      default:                  owner_d = OWN_DISP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      state_q <= S_IDLE;
      owner_q <= OWN_DISP;
      step_q  <= '0;
      last_q  <= 1'b1;
      pend_q  <= 1'b0;
      dstep_q <= 1'b0;
      cstep_q <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      if (reset) begin
        disp_q <= '0;
        ovr_q  <= 1'b0;
      end
    end else begin
      dstep_q <= 1'b0;
      cstep_q <= 1'b0;
      gnt_q   <= '0;
      pend_q  <= pend_d;
      if (ovr_set) ovr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (pend_q || (|req)) begin
            owner_q <= owner_d;
            step_q  <= '0;
            state_q <= S_STEP;
            dstep_q <= 1'b1;
            cstep_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_STEP: begin
          if (step_q == LAST_STEP) begin
            state_q <= S_SETTLE;
          end else begin
            step_q  <= step_q + 4'd1;
            cstep_q <= 1'b1;
          end
        end
        S_SETTLE: begin
          state_q <= S_DELIVER;
          unique case (owner_q)
            OWN_EXT0: begin
              gnt_q  <= 2'b01;
              rnd_q  <= mux_byte;
              last_q <= 1'b0;
            end
            OWN_EXT1: begin
              gnt_q  <= 2'b10;
              rnd_q  <= mux_byte;
              last_q <= 1'b1;
            end
            default: disp_q <= mux_byte;
          endcase
        end
        S_DELIVER: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_step    = dstep_q;
  assign ctrl_step    = cstep_q;
  assign gnt          = gnt_q;
  assign rnd_byte     = rnd_q;
  assign disp_byte    = disp_q;
  assign busy         = busy_q;
  assign disp_overrun = ovr_q;

endmodule

// File: tb/tb_prng_step_scheduler.sv
// Directed bench for prng_step_scheduler across four parameter sets.
// Grants of instance b are checked through an expected-result queue.
module tb_prng_step_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] mux;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mux_f(input int c);
    return 8'(c * 37 + 90);
  endfunction

  assign mux = mux_f(cyc);

  logic       en_a = 0, en_b = 0, en_c = 0, en_d = 0;
  logic [1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic       ds_a, cs_a, tk_a, bz_a, ov_a;
  logic       ds_b, cs_b, tk_b, bz_b, ov_b;
  logic       ds_c, cs_c, tk_c, bz_c, ov_c;
  logic       ds_d, cs_d, tk_d, bz_d, ov_d;
  logic [1:0] gn_a, gn_b, gn_c, gn_d;
  logic [7:0] rb_a, rb_b, rb_c, rb_d;
  logic [7:0] db_a, db_b, db_c, db_d;

  prng_step_scheduler #(.TICK_DIV(8), .CTRL_STEPS(1)) u_a (
    .clk(clk), .reset(rst), .en(en_a), .req(req_a), .mux_byte(mux),
    .data_step(ds_a), .ctrl_step(cs_a), .gnt(gn_a), .rnd_byte(rb_a),
    .disp_byte(db_a), .disp_tick(tk_a), .busy(bz_a), .disp_overrun(ov_a));

  prng_step_scheduler #(.TICK_DIV(1000), .CTRL_STEPS(1)) u_b (
    .clk(clk), .reset(rst), .en(en_b), .req(req_b), .mux_byte(mux),
    .data_step(ds_b), .ctrl_step(cs_b), .gnt(gn_b), .rnd_byte(rb_b),
    .disp_byte(db_b), .disp_tick(tk_b), .busy(bz_b), .disp_overrun(ov_b));

  prng_step_scheduler #(.TICK_DIV(1000), .CTRL_STEPS(3)) u_c (
    .clk(clk), .reset(rst), .en(en_c), .req(req_c), .mux_byte(mux),
    .data_step(ds_c), .ctrl_step(cs_c), .gnt(gn_c), .rnd_byte(rb_c),
    .disp_byte(db_c), .disp_tick(tk_c), .busy(bz_c), .disp_overrun(ov_c));

  prng_step_scheduler #(.TICK_DIV(2), .CTRL_STEPS(1)) u_d (
    .clk(clk), .reset(rst), .en(en_d), .req(req_d), .mux_byte(mux),
    .data_step(ds_d), .ctrl_step(cs_d), .gnt(gn_d), .rnd_byte(rb_d),
    .disp_byte(db_d), .disp_tick(tk_d), .busy(bz_d), .disp_overrun(ov_d));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         gcyc;
    logic [1:0] g;
    logic [7:0] b;
  } exp_t;

  exp_t sbq[$];
  int   d_gcyc = -1;

  always @(negedge clk) begin
    exp_t e;
    if (gn_b !== 2'b00) begin
      if (sbq.size() == 0) begin
        chk("b_unexpected_gnt", 32'(gn_b), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("b_gnt_cycle", cyc, e.gcyc);
        chk("b_gnt", 32'(gn_b), 32'(e.g));
        chk("b_rnd", 32'(rb_b), 32'(e.b));
      end
    end
  end

  always @(negedge clk) begin
    if (en_d)
      chk("d_gnt", 32'(gn_d), (cyc == d_gcyc) ? 32'd1 : 32'd0);
  end

  initial begin
    int c, t;
    logic [7:0] last_db;
    t = 0;
    last_db = '0;

    step(2);
    chk("rst_ds", 32'(ds_a), 0);
    chk("rst_cs", 32'(cs_a), 0);
    chk("rst_gnt", 32'(gn_a), 0);
    chk("rst_rnd", 32'(rb_a), 0);
    chk("rst_disp", 32'(db_a), 0);
    chk("rst_tick", 32'(tk_a), 0);
    chk("rst_busy", 32'(bz_a), 0);
    chk("rst_ovr", 32'(ov_a), 0);

    // Display refresh with TICK_DIV=8
    rst = 1'b0;
    en_a = 1'b1;
    step(7);
    chk("a_tick_early", 32'(tk_a), 0);
    step(1);
    for (int i = 0; i < 3; i++) begin
      t = cyc;
      chk("a_tick", 32'(tk_a), 1);
      step(1);
      chk("a_ds", 32'(ds_a), 1);
      chk("a_cs", 32'(cs_a), 1);
      chk("a_busy", 32'(bz_a), 1);
      chk("a_tick_pulse", 32'(tk_a), 0);
      step(1);
      chk("a_ds_off", 32'(ds_a), 0);
      chk("a_cs_off", 32'(cs_a), 0);
      step(1);
      last_db = mux_f(t + 2);
      chk("a_disp", 32'(db_a), 32'(last_db));
      chk("a_no_gnt", 32'(gn_a), 0);
      step(5);
    end
    chk("a_tick_last", 32'(tk_a), 1);
    chk("a_ovr", 32'(ov_a), 0);
    step(1);
    chk("a_ds_pre_abort", 32'(ds_a), 1);
    en_a = 1'b0;
    step(1);
    chk("a_abort_ds", 32'(ds_a), 0);
    chk("a_abort_cs", 32'(cs_a), 0);
    chk("a_abort_busy", 32'(bz_a), 0);
    chk("a_abort_tick", 32'(tk_a), 0);
    chk("a_abort_disp", 32'(db_a), 32'(last_db));
    step(3);
    chk("a_disp_held", 32'(db_a), 32'(last_db));
    en_a = 1'b1;
    step(7);
    chk("a_restart_early", 32'(tk_a), 0);
    step(1);
    chk("a_restart_tick", 32'(tk_a), 1);
    en_a = 1'b0;

    // Single external requester
    en_b = 1'b1;
    step(2);
    c = cyc;
    req_b = 2'b01;
    sbq.push_back('{c + 3, 2'b01, mux_f(c + 2)});
    step(3);
    req_b = 2'b00;
    step(10);
    chk("b_single_drained", sbq.size(), 0);
    chk("b_rnd_hold", 32'(rb_b), 32'(mux_f(c + 2)));

    // Round robin with both requesting, pointer reset by soft reset
    en_b = 1'b0;
    step(1);
    en_b = 1'b1;
    step(1);
    c = cyc;
    req_b = 2'b11;
    for (int k = 0; k < 4; k++)
      sbq.push_back('{c + 3 + 4 * k, (k % 2 == 0) ? 2'b01 : 2'b10,
                      mux_f(c + 2 + 4 * k)});
    step(15);
    req_b = 2'b00;
    step(6);
    chk("b_rr_drained", sbq.size(), 0);
    chk("b_rr_rnd_hold", 32'(rb_b), 32'(mux_f(c + 14)));

    // Abort during STEP
    req_b = 2'b10;
    step(1);
    chk("b_abort_pre_ds", 32'(ds_b), 1);
    en_b = 1'b0;
    req_b = 2'b00;
    step(1);
    chk("b_abort_ds", 32'(ds_b), 0);
    chk("b_abort_cs", 32'(cs_b), 0);
    chk("b_abort_gnt", 32'(gn_b), 0);
    chk("b_abort_busy", 32'(bz_b), 0);
    chk("b_abort_rnd", 32'(rb_b), 0);
    step(2);
    en_b = 1'b1;
    step(8);
    chk("b_abort_no_gnt", sbq.size(), 0);
    en_b = 1'b0;

    // CTRL_STEPS=3
    en_c = 1'b1;
    step(2);
    c = cyc;
    req_c = 2'b10;
    step(1);
    chk("c_ds1", 32'(ds_c), 1);
    chk("c_cs1", 32'(cs_c), 1);
    step(1);
    chk("c_ds2", 32'(ds_c), 0);
    chk("c_cs2", 32'(cs_c), 1);
    step(1);
    chk("c_ds3", 32'(ds_c), 0);
    chk("c_cs3", 32'(cs_c), 1);
    step(1);
    chk("c_cs_settle", 32'(cs_c), 0);
    chk("c_gnt_early", 32'(gn_c), 0);
    step(1);
    chk("c_gnt", 32'(gn_c), 2);
    chk("c_rnd", 32'(rb_c), 32'(mux_f(c + 4)));
    req_c = 2'b00;
    step(1);
    chk("c_gnt_pulse", 32'(gn_c), 0);
    step(5);
    chk("c_idle", 32'(bz_c), 0);
    en_c = 1'b0;

    // TICK_DIV=2: display starves externals and overruns
    c = cyc;
    d_gcyc = c + 3;
    en_d = 1'b1;
    req_d = 2'b01;
    step(3);
    chk("d_rnd", 32'(rb_d), 32'(mux_f(c + 2)));
    chk("d_ovr_early", 32'(ov_d), 0);
    step(1);
    chk("d_ovr", 32'(ov_d), 1);
    step(3);
    chk("d_disp", 32'(db_d), 32'(mux_f(c + 6)));
    step(25);
    chk("d_ovr_sticky", 32'(ov_d), 1);
    en_d = 1'b0;
    step(1);
    chk("d_ovr_held", 32'(ov_d), 1);
    chk("d_busy_off", 32'(bz_d), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
